// File: rtl/mem_test_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
package mem_test_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    M0    = 4'd1,
    M1    = 4'd2,
    M2    = 4'd3,
    M3    = 4'd4,
    M4    = 4'd5,
    M5    = 4'd6,
    DRAIN = 4'd7,
    DONE  = 4'd8
  } bist_state_t;

  localparam int DATA_W_DEF = 8;
  localparam logic [DATA_W_DEF-1:0] D0 = {DATA_W_DEF{1'b0}};
  localparam logic [DATA_W_DEF-1:0] D1 = {DATA_W_DEF{1'b1}};

  // Backgrounds are stored as one bit and replicated to the word width at use.
  typedef struct packed {
    logic has_read;
    logic has_write;
    logic read_bg;
    logic write_bg;
  } elem_op_t;

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic elem_op_t elem_op(input logic [2:0] e);
    case (e)
      3'd0:    return elem_op_t'(4'b0100);
      3'd1:    return elem_op_t'(4'b1101);
      3'd2:    return elem_op_t'(4'b1110);
      3'd3:    return elem_op_t'(4'b1101);
      3'd4:    return elem_op_t'(4'b1110);
      3'd5:    return elem_op_t'(4'b1000);
      default: return elem_op_t'(4'b0000);
    endcase
  endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// SRAM-side port of the BIST controller; master drives the macro, slave is the macro.
interface sram_march_bist_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              sram_we;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_data_in;
  logic [DATA_W-1:0] sram_data_out;

  modport master (output sram_we, sram_address, sram_data_in, input sram_data_out);
  modport slave  (input sram_we, sram_address, sram_data_in, output sram_data_out);
endinterface

// File: rtl/bist_compare_pipe.sv
// Read-data delay line aligned to the SRAM latency, comparator, saturating error
// counter and sticky first-failure capture.
module bist_compare_pipe #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              miss_o,
  output logic [7:0]        err_count_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_exp_o,
  output logic [DATA_W-1:0] fail_act_o
);
  localparam int LAST = READ_LATENCY - 1;

  logic [READ_LATENCY-1:0]             vld_q;
  logic [READ_LATENCY-1:0][ADDR_W-1:0] addr_q;
  logic [READ_LATENCY-1:0][DATA_W-1:0] exp_q;
  logic [7:0]                          err_q;
  logic [ADDR_W-1:0]                   faddr_q;
  logic [DATA_W-1:0]                   fexp_q;
  logic [DATA_W-1:0]                   fact_q;

  assign miss_o = vld_q[LAST] && (rd_data_i != exp_q[LAST]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      addr_q  <= '0;
      exp_q   <= '0;
      err_q   <= '0;
      faddr_q <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
    end else if (clr_i) begin
      vld_q   <= '0;
      err_q   <= '0;
      faddr_q <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
    end else begin
      vld_q[0]  <= push_i;
      addr_q[0] <= addr_i;
      exp_q[0]  <= exp_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
      if (miss_o) begin
        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
        if (err_q == 8'd0) begin
          faddr_q <= addr_q[LAST];
          fexp_q  <= exp_q[LAST];
          fact_q  <= rd_data_i;
        end
      end
    end
  end

  assign err_count_o = err_q;
  assign fail_addr_o = faddr_q;
  assign fail_exp_o  = fexp_q;
  assign fail_act_o  = fact_q;

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller: element sequencer and address generator; compares
// are retired READ_LATENCY cycles later by bist_compare_pipe.
//   state | meaning
//   IDLE  | waiting for start, SRAM released
//   M0-M5 | March elements (M3/M4 descending, M1-M4 read+write per address)
//   DRAIN | waiting for the last reads to retire
//   DONE  | result held until the next start
module sram_march_bist
  import mem_test_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_expected,
  output logic [DATA_W-1:0] fail_actual,
  output logic [7:0]        err_count,
  sram_march_bist_if.master sram
);
  bist_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [1:0]        drain_q, drain_d;
  logic              pass_q, pass_d;
  logic              clr, push, miss, last;
  logic [2:0]        elem, nelem;
  elem_op_t          op, nop;

  assign elem  = 3'(state_q - 4'd1);
  assign nelem = elem + 3'd1;
  assign op    = elem_op(elem);
  assign nop   = elem_op(nelem);
  assign last  = elem_down(elem) ? (addr_q == '0) : (addr_q == '1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    din_d   = '0;
    drain_d = drain_q;
    pass_d  = pass_q;
    clr     = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = M0;
          addr_d  = '0;
          we_d    = 1'b1;
          pass_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      M0, M1, M2, M3, M4, M5: begin
        push = op.has_read && !we_q;
        if (op.has_read && op.has_write && !we_q) begin
          we_d  = 1'b1;
          din_d = {DATA_W{op.write_bg}};
        end else if (!last) begin
          addr_d = elem_down(elem) ? addr_q - 1'b1 : addr_q + 1'b1;
          we_d   = !op.has_read;
          din_d  = op.has_read ? '0 : {DATA_W{op.write_bg}};
        end else if (state_q == M5) begin
          state_d = DRAIN;
          drain_d = 2'(READ_LATENCY - 1);
        end else begin
          // Next element starts on the very next cycle from its own end of the array.
          state_d = bist_state_t'(state_q + 4'd1);
          addr_d  = {ADDR_W{elem_down(nelem)}};
          we_d    = !nop.has_read;
          din_d   = nop.has_read ? '0 : {DATA_W{nop.write_bg}};
        end
      end
      DRAIN: begin
        if (drain_q == 2'd0) begin
          state_d = DONE;
          pass_d  = (err_count == 8'd0) && !miss;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
      drain_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
      drain_q <= drain_d;
      pass_q  <= pass_d;
    end
  end

  bist_compare_pipe #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .READ_LATENCY(READ_LATENCY)
  ) u_cmp (
    .clk        (clk),
    .rst        (reset),
    .clr_i      (clr),
    .push_i     (push),
    .addr_i     (addr_q),
    .exp_i      ({DATA_W{op.read_bg}}),
    .rd_data_i  (sram.sram_data_out),
    .miss_o     (miss),
    .err_count_o(err_count),
    .fail_addr_o(fail_addr),
    .fail_exp_o (fail_expected),
    .fail_act_o (fail_actual)
  );

  assign busy              = (state_q != IDLE) && (state_q != DONE);
  assign done              = (state_q == DONE);
  assign pass              = pass_q;
  assign sram.sram_we      = we_q;
  assign sram.sram_address = addr_q;
  assign sram.sram_data_in = din_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist: 8-word SRAM models with injectable faults,
// one instance at read latency 1 and one at read latency 3.
module tb_sram_march_bist;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;

  sram_march_bist_if #(.ADDR_W(3), .DATA_W(8)) ifa ();
  sram_march_bist_if #(.ADDR_W(3), .DATA_W(8)) ifb ();

  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [2:0] faddr_a, faddr_b;
  logic [7:0] fexp_a, fact_a, err_a, fexp_b, fact_b, err_b;

  sram_march_bist #(.ADDR_W(3), .DATA_W(8), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_addr(faddr_a), .fail_expected(fexp_a), .fail_actual(fact_a), .err_count(err_a),
    .sram(ifa));

  sram_march_bist #(.ADDR_W(3), .DATA_W(8), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_addr(faddr_b), .fail_expected(fexp_b), .fail_actual(fact_b), .err_count(err_b),
    .sram(ifb));

  // SRAM model A: latency 1, optional stuck-at-1 mask and 2->6 coupling fault
  logic [7:0] mem_a [8];
  logic [7:0] rd_a;
  logic [2:0] fa_addr = 3'd0;
  logic [7:0] fa_sa1 = 8'h00;
  logic       cpl_a = 1'b0;
  always @(posedge clk) begin
    if (ifa.sram_we) begin
      mem_a[ifa.sram_address] <= ifa.sram_data_in;
      if (cpl_a && ifa.sram_address == 3'd2 && ifa.sram_data_in == 8'hFF) mem_a[6] <= 8'hFF;
    end
    rd_a <= mem_a[ifa.sram_address] | ((ifa.sram_address == fa_addr) ? fa_sa1 : 8'h00);
  end
  assign ifa.sram_data_out = rd_a;

  // SRAM model B: latency 3, address 0 stuck-at-0 on every bit
  logic [7:0] mem_b [8];
  logic [7:0] rb0, rb1, rb2;
  always @(posedge clk) begin
    if (ifb.sram_we) mem_b[ifb.sram_address] <= ifb.sram_data_in;
    rb0 <= (ifb.sram_address == 3'd0) ? 8'h00 : mem_b[ifb.sram_address];
    rb1 <= rb0;
    rb2 <= rb1;
  end
  assign ifb.sram_data_out = rb2;

  int n_chk = 0, n_fail = 0;
  logic [3:0] log_aw [0:255];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_a(input bit start_at_end, output int cyc);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 200) begin
      cyc++;
      log_aw[cyc] = {ifa.sram_address, ifa.sram_we};
      if (start_at_end && cyc == 81) start_a = 1'b1;
      @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  task automatic check_result_a(input string tag, input bit exp_pass, input logic [7:0] exp_err,
                                input logic [2:0] exp_fa, input logic [7:0] exp_fe,
                                input logic [7:0] exp_fx);
    check_val({tag, "_done"}, 32'(done_a), 32'd1);
    check_val({tag, "_pass"}, 32'(pass_a), 32'(exp_pass));
    check_val({tag, "_err"}, 32'(err_a), 32'(exp_err));
    check_val({tag, "_faddr"}, 32'(faddr_a), 32'(exp_fa));
    check_val({tag, "_fexp"}, 32'(fexp_a), 32'(exp_fe));
    check_val({tag, "_fact"}, 32'(fact_a), 32'(exp_fx));
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_busy", 32'(busy_a), 32'd0);
    check_val("rst_done", 32'(done_a), 32'd0);
    check_val("rst_pass", 32'(pass_a), 32'd0);
    check_val("rst_err", 32'(err_a), 32'd0);
    check_val("rst_we", 32'(ifa.sram_we), 32'd0);
    check_val("rst_addr", 32'(ifa.sram_address), 32'd0);

    // fault-free run, with the address sequence logged
    run_a(1'b0, cyc);
    check_val("clean_busy_cycles", 32'(cyc), 32'd81);
    check_result_a("clean", 1'b1, 8'd0, 3'd0, 8'h00, 8'h00);
    check_val("m0_first", 32'(log_aw[1]), 32'({3'd0, 1'b1}));
    check_val("m1_first", 32'(log_aw[9]), 32'({3'd0, 1'b0}));
    for (int k = 0; k < 16; k++) begin
      logic [2:0] ea;
      ea = 3'(7 - k / 2);
      check_val($sformatf("m3_seq_%0d", k), 32'(log_aw[41 + k]), 32'({ea, 1'(k % 2)}));
    end
    check_val("m4_first", 32'(log_aw[57]), 32'({3'd7, 1'b0}));
    check_val("m5_first", 32'(log_aw[73]), 32'({3'd0, 1'b0}));

    // bit 2 of address 5 stuck-at-1
    fa_addr = 3'd5; fa_sa1 = 8'h04;
    run_a(1'b0, cyc);
    check_val("sa1_busy_cycles", 32'(cyc), 32'd81);
    check_result_a("sa1", 1'b0, 8'd3, 3'd5, 8'h00, 8'h04);
    fa_sa1 = 8'h00;

    // coupling fault plus start held on the final DRAIN cycle
    cpl_a = 1'b1;
    run_a(1'b1, cyc);
    check_val("cpl_busy_cycles", 32'(cyc), 32'd81);
    check_result_a("cpl", 1'b0, 8'd1, 3'd6, 8'h00, 8'hFF);
    @(negedge clk);
    check_val("start_at_drain_ignored", 32'(busy_a), 32'd0);
    check_val("start_at_drain_done", 32'(done_a), 32'd1);
    cpl_a = 1'b0;

    // reset during a write cycle of M1
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    cyc = 1;
    while (cyc < 20) begin @(negedge clk); cyc++; end
    check_val("pre_reset_we", 32'(ifa.sram_we), 32'd1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_we", 32'(ifa.sram_we), 32'd0);
    check_val("mid_rst_busy", 32'(busy_a), 32'd0);
    check_val("mid_rst_done", 32'(done_a), 32'd0);
    check_val("mid_rst_addr", 32'(ifa.sram_address), 32'd0);
    check_val("mid_rst_err", 32'(err_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_a(1'b0, cyc);
    check_val("rerun_busy_cycles", 32'(cyc), 32'd81);
    check_result_a("rerun", 1'b1, 8'd0, 3'd0, 8'h00, 8'h00);

    // latency 3, address 0 stuck-at-0, extra start while busy
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    cyc = 0;
    while (busy_b && cyc < 300) begin
      cyc++;
      start_b = (cyc == 10);
      @(negedge clk);
    end
    start_b = 1'b0;
    check_val("rl3_busy_cycles", 32'(cyc), 32'd83);
    check_val("rl3_done", 32'(done_b), 32'd1);
    check_val("rl3_pass", 32'(pass_b), 32'd0);
    check_val("rl3_err", 32'(err_b), 32'd2);
    check_val("rl3_faddr", 32'(faddr_b), 32'd0);
    check_val("rl3_fexp", 32'(fexp_b), 32'hFF);
    check_val("rl3_fact", 32'(fact_b), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
